bus_cycle_sequencer: RTL and testbench

Multicycle sequencer for the MIPS CPU's Avalon memory-mapped bus master. It drives the FETCH/DECODE/EXEC/MEM/WB state sequence that the control-signal decoder consumes, and owns the read/write/byteenable handshake, including waitrequest stalls. It also detects halt and access faults and maintains the cycle counters used by the testbench. It replaces the free-running state machine in the CPU top level and sits between the instruction decoder and the bus pins.

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/sat_counter.sv | 33 +++
 rtl/bus_cycle_sequencer.sv | 148 ++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the multicycle CPU bus sequencer: state and fault encodings,
// access-size codes and the byte-lane lookup shared with the load/store aligner.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_IDLE   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_TIMEOUT  = 2'b10,
    FAULT_SIZE     = 2'b11
  } fault_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Little-endian lane mask; illegal sizes enable no lanes.
  function automatic logic [3:0] byte_lanes(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] lanes;
    case (size)
      SIZE_BYTE: lanes = 4'b0001 << addr_lo;
      SIZE_HALF: lanes = 4'b0011 << addr_lo;
      SIZE_WORD: lanes = 4'b1111;
      default:   lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SIZE_HALF: ok = ~addr_lo[0];
      SIZE_WORD: ok = (addr_lo == 2'b00);
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the Avalon master handshake,
// with halt/fault detection and stall and retirement counters.
module bus_cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             needs_wb,
  input  logic             halt_req,
  input  logic [1:0]       mem_size,
  input  logic [1:0]       addr_lo,
  input  logic             waitrequest,
  output logic [2:0]       state,
  output logic             read,
  output logic             write,
  output logic [3:0]       byteenable,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             reg_write_en,
  output logic             stall,
  output logic             active,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] instr_retired
);

  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
  localparam bit TIMEOUT_EN = (MAX_WAIT > 0);

  state_t     state_q, state_d;
  fault_t     fault_q, fault_d;
  logic       ld_q, ld_d, st_q, st_d;
  logic [1:0] size_q, size_d, addr_q, addr_d;

  logic              stall_c, timeout_c, retire_c, mem_op_c;
  logic [WAIT_W-1:0] wait_cnt;

  assign mem_op_c  = is_load | is_store;
  assign stall_c   = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && waitrequest;
  // Fires on the last tolerated stall so the strobe is gone on the following cycle.
  assign timeout_c = TIMEOUT_EN && stall_c && (wait_cnt == WAIT_LAST);
  assign retire_c  = ((state_q == ST_EXEC) && !halt_req && !mem_op_c && !needs_wb)
                   || ((state_q == ST_MEM) && !ld_q && !waitrequest)
                   || (state_q == ST_WB);

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    ld_d    = ld_q;
    st_d    = st_q;
    size_d  = size_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (timeout_c) begin
          state_d = ST_HALT;
          fault_d = FAULT_TIMEOUT;
        end else if (!waitrequest) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        ld_d   = is_load;
        st_d   = is_store;
        size_d = mem_size;
        addr_d = addr_lo;
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (mem_op_c && (mem_size == 2'b11)) begin
          state_d = ST_HALT;
          fault_d = FAULT_SIZE;
        end else if (mem_op_c && !is_aligned(mem_size, addr_lo)) begin
          state_d = ST_HALT;
          fault_d = FAULT_MISALIGN;
        end else if (mem_op_c) begin
          state_d = ST_MEM;
        end else if (needs_wb) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (timeout_c) begin
          state_d = ST_HALT;
          fault_d = FAULT_TIMEOUT;
        end else if (!waitrequest) begin
          state_d = ld_q ? ST_WB : ST_FETCH;
        end
      end
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      fault_q <= FAULT_NONE;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
    end
  end

  // A load takes priority if the decoder ever flags both.
  assign state        = state_q;
  assign read         = (state_q == ST_FETCH) || ((state_q == ST_MEM) && ld_q);
  assign write        = (state_q == ST_MEM) && st_q && !ld_q;
  assign byteenable   = (state_q == ST_FETCH) ? 4'b1111 :
                        (state_q == ST_MEM)   ? byte_lanes(size_q, addr_q) : 4'b0000;
  assign ir_write     = (state_q == ST_FETCH) && !waitrequest;
  assign mdr_write    = (state_q == ST_MEM) && ld_q && !waitrequest;
  assign reg_write_en = (state_q == ST_WB);
  assign stall        = stall_c;
  assign active       = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign fault        = fault_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(reset), .clear(1'b0), .inc(stall_c), .count(stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk(clk), .rst_n(reset), .clear(1'b0), .inc(retire_c), .count(instr_retired)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk(clk), .rst_n(reset), .clear(!stall_c), .inc(stall_c), .count(wait_cnt)
  );

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Self-checking bench: per-instruction expected cycle traces from a behavioural model,
// plus reset, timeout, counter saturation and asynchronous reset scenarios.
module tb_bus_cycle_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic is_load = 0, is_store = 0, needs_wb = 0, halt_req = 0, waitrequest = 0;
  logic [1:0] mem_size = 0, addr_lo = 0;

  logic [2:0]  state;
  logic        read, write, ir_write, mdr_write, reg_write_en, stall, active;
  logic [3:0]  byteenable;
  logic [1:0]  fault;
  logic [31:0] stall_cycles, instr_retired;

  logic [2:0]  b_state;
  logic        b_read, b_write, b_ir_write, b_mdr_write, b_reg_write_en, b_stall, b_active;
  logic [3:0]  b_byteenable;
  logic [1:0]  b_fault;
  logic [2:0]  b_stall_cycles, b_instr_retired;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_ret   = 0;

  typedef struct {
    bit          wr;
    bit          exec;
    logic [15:0] exp;
  } cyc_t;

  always #5 clk = ~clk;

  bus_cycle_sequencer #(.CNT_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .is_load(is_load), .is_store(is_store), .needs_wb(needs_wb),
    .halt_req(halt_req), .mem_size(mem_size), .addr_lo(addr_lo), .waitrequest(waitrequest),
    .state(state), .read(read), .write(write), .byteenable(byteenable), .ir_write(ir_write),
    .mdr_write(mdr_write), .reg_write_en(reg_write_en), .stall(stall), .active(active),
    .fault(fault), .stall_cycles(stall_cycles), .instr_retired(instr_retired)
  );

  // Narrow counters and no timeout: exercises saturation and the disabled-timeout case.
  bus_cycle_sequencer #(.CNT_W(3), .MAX_WAIT(0)) dut_sat (
    .clk(clk), .reset(reset), .is_load(is_load), .is_store(is_store), .needs_wb(needs_wb),
    .halt_req(halt_req), .mem_size(mem_size), .addr_lo(addr_lo), .waitrequest(waitrequest),
    .state(b_state), .read(b_read), .write(b_write), .byteenable(b_byteenable),
    .ir_write(b_ir_write), .mdr_write(b_mdr_write), .reg_write_en(b_reg_write_en),
    .stall(b_stall), .active(b_active), .fault(b_fault), .stall_cycles(b_stall_cycles),
    .instr_retired(b_instr_retired)
  );

  function automatic logic [15:0] outs();
    return {state, read, write, byteenable, ir_write, mdr_write, reg_write_en, stall, active, fault};
  endfunction

  function automatic logic [21:0] outs_b();
    return {b_state, b_read, b_write, b_byteenable, b_ir_write, b_mdr_write, b_reg_write_en,
            b_stall, b_active, b_fault, b_stall_cycles, b_instr_retired};
  endfunction

  function automatic logic [15:0] vec(input int st, input bit rd, input bit wr,
                                      input logic [3:0] be, input bit irw, input bit mdw,
                                      input bit rwe, input bit stl, input bit act,
                                      input logic [1:0] flt);
    return {3'(st), rd, wr, be, irw, mdw, rwe, stl, act, flt};
  endfunction

  // Lanes from access width in bytes shifted to the byte offset.
  function automatic logic [3:0] model_be(input int sz, input int ad);
    int nbytes;
    nbytes = 1 << sz;
    return 4'(((1 << nbytes) - 1) << ad);
  endfunction

  task automatic scramble();
    is_load  = 1'($urandom);
    is_store = 1'($urandom);
    needs_wb = 1'($urandom);
    halt_req = 1'($urandom);
    mem_size = 2'($urandom);
    addr_lo  = 2'($urandom);
  endtask

  task automatic run_instr(input string name, input bit ld, input bit st, input bit wb,
                           input bit hlt, input int sz, input int ad, input int fw,
                           input int mw, output bit halted);
    cyc_t tr[$];
    int   pre_stall, pre_ret, nbytes, flt, outcome;
    bit   mem;
    pre_stall = exp_stall;
    pre_ret   = exp_ret;
    halted    = 1'b0;
    mem       = ld || st;
    nbytes    = 1 << sz;
    flt       = 0;
    for (int i = 0; i <= fw; i++)
      tr.push_back('{wr: (i < fw), exec: 1'b0,
                     exp: vec(0, 1, 0, 4'hf, i == fw, 0, 0, i < fw, 1, 2'd0)});
    exp_stall += fw;
    tr.push_back('{wr: 1'($urandom), exec: 1'b0, exp: vec(1, 0, 0, 4'h0, 0, 0, 0, 0, 1, 2'd0)});
    tr.push_back('{wr: 1'($urandom), exec: 1'b1, exp: vec(2, 0, 0, 4'h0, 0, 0, 0, 0, 1, 2'd0)});
    // outcome: 0 back to fetch, 4 writeback, 5 halt
    if (hlt) begin
      outcome = 5;
    end else if (mem && sz == 3) begin
      outcome = 5; flt = 3;
    end else if (mem && (ad % nbytes) != 0) begin
      outcome = 5; flt = 1;
    end else if (mem) begin
      for (int j = 0; j <= mw; j++)
        tr.push_back('{wr: (j < mw), exec: 1'b0,
                       exp: vec(3, ld, st && !ld, model_be(sz, ad), 0, ld && (j == mw), 0,
                                j < mw, 1, 2'd0)});
      exp_stall += mw;
      outcome = ld ? 4 : 0;
    end else begin
      outcome = wb ? 4 : 0;
    end
    if (outcome == 4)
      tr.push_back('{wr: 1'($urandom), exec: 1'b0, exp: vec(4, 0, 0, 4'h0, 0, 0, 1, 0, 1, 2'd0)});
    if (outcome != 5)
      exp_ret++;
    if (outcome == 5)
      repeat (2)
        tr.push_back('{wr: 1'($urandom), exec: 1'b0,
                       exp: vec(5, 0, 0, 4'h0, 0, 0, 0, 0, 0, 2'(flt))});
    foreach (tr[k]) begin
      @(negedge clk);
      waitrequest = tr[k].wr;
      if (tr[k].exec) begin
        is_load = ld; is_store = st; needs_wb = wb; halt_req = hlt;
        mem_size = 2'(sz); addr_lo = 2'(ad);
      end else begin
        scramble();
      end
      #1;
      n_checks++;
      if (outs() !== tr[k].exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d outputs: got %h expected %h", name, k, outs(), tr[k].exp);
      end
      if (k == 0) begin
        n_checks++;
        if (stall_cycles !== 32'(pre_stall) || instr_retired !== 32'(pre_ret)) begin
          n_fail++;
          $display("FAIL %s counters at fetch: got stall=%0d retired=%0d expected stall=%0d retired=%0d",
                   name, stall_cycles, instr_retired, pre_stall, pre_ret);
        end
      end
    end
    if (outcome == 5) begin
      halted = 1'b1;
      n_checks++;
      if (stall_cycles !== 32'(exp_stall) || instr_retired !== 32'(exp_ret)) begin
        n_fail++;
        $display("FAIL %s counters in halt: got stall=%0d retired=%0d expected stall=%0d retired=%0d",
                 name, stall_cycles, instr_retired, exp_stall, exp_ret);
      end
    end
    $display("txn %s ld=%0b st=%0b wb=%0b halt=%0b size=%0d addr=%0d fw=%0d mw=%0d -> outcome %0d",
             name, ld, st, wb, hlt, sz, ad, fw, mw, outcome);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({outs(), stall_cycles, instr_retired} !== {vec(6, 0, 0, 4'h0, 0, 0, 0, 0, 0, 2'd0), 64'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got %h stall=%0d retired=%0d expected %h with zero counters",
               outs(), stall_cycles, instr_retired, vec(6, 0, 0, 4'h0, 0, 0, 0, 0, 0, 2'd0));
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (outs() !== vec(6, 0, 0, 4'h0, 0, 0, 0, 0, 0, 2'd0)) begin
      n_fail++;
      $display("FAIL idle_after_release: got %h expected %h", outs(), vec(6, 0, 0, 4'h0, 0, 0, 0, 0, 0, 2'd0));
    end
    exp_stall = 0;
    exp_ret   = 0;
    $display("txn reset done");
  endtask

  task automatic test_alu();
    bit h;
    run_instr("alu_wb", 0, 0, 1, 0, 0, 0, 0, 0, h);
  endtask

  task automatic test_fetch_stall();
    bit h;
    run_instr("fetch_stall3", 0, 0, 0, 0, 2, 0, 3, 0, h);
    run_instr("after_stall", 0, 0, 1, 0, 0, 0, 0, 0, h);
  endtask

  task automatic test_store_half();
    bit h;
    run_instr("st_half_a2", 0, 1, 0, 0, 1, 2, 0, 1, h);
    run_instr("st_half_a1", 0, 1, 0, 0, 1, 1, 0, 0, h);
    test_reset();
  endtask

  task automatic test_load_byte();
    bit h;
    run_instr("ld_byte_a3", 1, 0, 0, 0, 0, 3, 1, 2, h);
    run_instr("after_load", 0, 0, 0, 0, 0, 0, 0, 0, h);
  endtask

  task automatic test_random();
    bit h;
    int r;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      run_instr($sformatf("rand%0d", n), (r >= 3 && r <= 5), (r >= 6 && r <= 8),
                1'($urandom), (r == 9), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), h);
      if (h) test_reset();
    end
  endtask

  task automatic test_timeout_sat();
    logic [15:0] exp_a;
    test_reset();
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      waitrequest = 1'b1;
      scramble();
      #1;
      exp_a = (i < 4) ? vec(0, 1, 0, 4'hf, 0, 0, 0, 1, 1, 2'd0)
                      : vec(5, 0, 0, 4'h0, 0, 0, 0, 0, 0, 2'd2);
      n_checks++;
      if (outs() !== exp_a) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: got %h expected %h", i, outs(), exp_a);
      end
      n_checks++;
      if (outs_b() !== {vec(0, 1, 0, 4'hf, 0, 0, 0, 1, 1, 2'd0), 3'((i > 7) ? 7 : i), 3'd0}) begin
        n_fail++;
        $display("FAIL no_timeout_sat cycle %0d: got %h expected %h", i, outs_b(),
                 {vec(0, 1, 0, 4'hf, 0, 0, 0, 1, 1, 2'd0), 3'((i > 7) ? 7 : i), 3'd0});
      end
    end
    n_checks++;
    if (stall_cycles !== 32'd4 || instr_retired !== 32'd0) begin
      n_fail++;
      $display("FAIL timeout_counters: got stall=%0d retired=%0d expected stall=4 retired=0",
               stall_cycles, instr_retired);
    end
    $display("txn timeout/saturation run done");
    waitrequest = 1'b0;
    test_reset();
  endtask

  task automatic test_halt_async();
    bit h;
    run_instr("halt_req", 0, 0, 1, 1, 0, 0, 1, 0, h);
    test_reset();
    run_instr("pre_async", 0, 0, 1, 0, 0, 0, 0, 0, h);
    @(negedge clk);
    waitrequest = 1'b1;
    #1;
    n_checks++;
    if (outs() !== vec(0, 1, 0, 4'hf, 0, 0, 0, 1, 1, 2'd0)) begin
      n_fail++;
      $display("FAIL async_pre_fetch: got %h expected %h", outs(), vec(0, 1, 0, 4'hf, 0, 0, 0, 1, 1, 2'd0));
    end
    @(negedge clk);
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({outs(), stall_cycles, instr_retired} !== {vec(6, 0, 0, 4'h0, 0, 0, 0, 0, 0, 2'd0), 64'd0}) begin
      n_fail++;
      $display("FAIL async_reset_mid_fetch: got %h stall=%0d retired=%0d expected %h with zero counters",
               outs(), stall_cycles, instr_retired, vec(6, 0, 0, 4'h0, 0, 0, 0, 0, 0, 2'd0));
    end
    $display("txn async reset mid-fetch done");
    waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_stall = 0;
    exp_ret   = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_alu();
    test_fetch_stall();
    test_store_half();
    test_load_byte();
    test_random();
    test_timeout_sat();
    test_halt_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
